// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF sync, debounce, one-cycle press/release pulses.
// Define BTN_AUTOREPEAT_EN to build the per-channel auto-repeat on btn_pulse.
module btn_conditioner #(
    parameter int N_BTN         = 5,
    parameter int DB_CYCLES     = 1_000_000,
    parameter int RPT_DELAY_CYC = 50_000_000,
    parameter int RPT_RATE_CYC  = 10_000_000
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_release
);

    localparam int DbW = $clog2(DB_CYCLES + 1);
    localparam logic [DbW-1:0] DbMax = DbW'(DB_CYCLES - 1);

    logic [N_BTN-1:0]          sync1_q;
    logic [N_BTN-1:0]          sync2_q;
    logic [N_BTN-1:0]          level_q;
    logic [N_BTN-1:0]          level_d;
    logic [N_BTN-1:0]          press_q;
    logic [N_BTN-1:0]          press_d;
    logic [N_BTN-1:0]          rel_q;
    logic [N_BTN-1:0]          rel_d;
    logic [N_BTN-1:0][DbW-1:0] db_cnt_q;
    logic [N_BTN-1:0][DbW-1:0] db_cnt_d;

    // Any cycle where sync agrees with the accepted level restarts the count.
    always_comb begin
        level_d  = level_q;
        press_d  = '0;
        rel_d    = '0;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbMax) begin
                level_d[i]  = ~level_q[i];
                press_d[i]  = ~level_q[i];
                rel_d[i]    = level_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '0;
            press_q  <= '0;
            rel_q    <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_release = rel_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RptMax = (RPT_DELAY_CYC > RPT_RATE_CYC) ?
                            RPT_DELAY_CYC : RPT_RATE_CYC;
    localparam int RptW = $clog2(RptMax + 1);
    localparam logic [RptW-1:0] DlyLast  = RptW'(RPT_DELAY_CYC - 1);
    localparam logic [RptW-1:0] RateLast = RptW'(RPT_RATE_CYC - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    logic [N_BTN-1:0] rpt_hit;

    for (genvar g = 0; g < N_BTN; g++) begin : g_rpt
        rpt_state_e      state_q;
        logic [RptW-1:0] cnt_q;
        logic            hit_q;

        // A falling level wins over a coinciding repeat tick.
        always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
            if (!CPU_RESETN) begin
                state_q <= RPT_IDLE;
                cnt_q   <= '0;
                hit_q   <= 1'b0;
            end else begin
                hit_q <= 1'b0;
                unique case (state_q)
                    RPT_IDLE: begin
                        if (press_d[g]) begin
                            state_q <= RPT_DELAY;
                            cnt_q   <= '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (rel_d[g]) begin
                            state_q <= RPT_IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == DlyLast) begin
                            state_q <= RPT_REPEAT;
                            cnt_q   <= '0;
                            hit_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + RptW'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (rel_d[g]) begin
                            state_q <= RPT_IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == RateLast) begin
                            cnt_q <= '0;
                            hit_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + RptW'(1);
                        end
                    end
                    default: begin
                        state_q <= RPT_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign rpt_hit[g] = hit_q;
    end

    assign btn_pulse = press_q | rpt_hit;
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{RPT_DELAY_CYC, RPT_RATE_CYC};
    assign btn_pulse      = press_q;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (N_BTN=2, DB=4, delay=20, rate=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_btn_conditioner;

    logic       clk;
    logic       rst_n;
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] pul;
    logic [1:0] rel;

    int n_chk;
    int n_bad;

    btn_conditioner #(
        .N_BTN         (2),
        .DB_CYCLES     (4),
        .RPT_DELAY_CYC (20),
        .RPT_RATE_CYC  (8)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .btn_raw     (raw),
        .btn_level   (lvl),
        .btn_pulse   (pul),
        .btn_release (rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk3(input string tag, input logic [1:0] el,
                        input logic [1:0] ep, input logic [1:0] er);
        chk({tag, "_lvl"}, 32'(lvl), 32'(el));
        chk({tag, "_pul"}, 32'(pul), 32'(ep));
        chk({tag, "_rel"}, 32'(rel), 32'(er));
    endtask

    // Clean edge: level moves on the 6th clock after raw changes.
    task automatic edge_run(input string tag, input logic [1:0] r,
                            input logic [1:0] lb, input logic [1:0] la,
                            input logic [1:0] ep, input logic [1:0] er);
        raw = r;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk3($sformatf("%s%0d", tag, k),
                 (k >= 6) ? la : lb,
                 (k == 6) ? ep : 2'b00,
                 (k == 6) ? er : 2'b00);
        end
    endtask

    initial begin
        logic       seq [7];
        logic       exp_p;
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        raw   = 2'b11;

        // 1. button held through reset
        for (int k = 0; k < 3; k++) begin
            tick();
            chk3($sformatf("rst%0d", k), 2'b00, 2'b00, 2'b00);
        end
        rst_n = 1'b1;
        edge_run("rstrel", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00);
        edge_run("fallab", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);

        // 2. bounce on channel 0
        seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            raw = {1'b0, seq[i]};
            if (i < 6) begin
                tick();
                chk3($sformatf("bnc%0d", i), 2'b00, 2'b00, 2'b00);
            end
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk3($sformatf("bncend%0d", k),
                 (k >= 6) ? 2'b01 : 2'b00,
                 (k == 6) ? 2'b01 : 2'b00, 2'b00);
        end
        edge_run("bncfal", 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);

        // 3. 3-clock glitch on channel 1 is rejected
        for (int k = 0; k < 15; k++) begin
            raw = (k < 3) ? 2'b10 : 2'b00;
            tick();
            chk3($sformatf("gl%0d", k), 2'b00, 2'b00, 2'b00);
        end

        // 4. simultaneous press and release
        edge_run("simr", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00);
        edge_run("simf", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);

        // 5. long hold on channel 0; level falls at +60
        raw = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk3($sformatf("hpre%0d", k), 2'b00, 2'b00, 2'b00);
        end
        for (int j = 0; j <= 64; j++) begin
            tick();
`ifdef BTN_AUTOREPEAT_EN
            exp_p = (j == 0) || (j == 20) || (j == 28) ||
                    (j == 36) || (j == 44) || (j == 52);
`else
            exp_p = (j == 0);
`endif
            chk3($sformatf("hold%0d", j),
                 (j < 60) ? 2'b01 : 2'b00,
                 {1'b0, exp_p},
                 (j == 60) ? 2'b01 : 2'b00);
            if (j == 54) raw = 2'b00;
        end

        // 6. reset while held (in REPEAT when auto-repeat is built)
        raw = 2'b01;
        for (int k = 0; k < 31; k++) tick();
        chk("mid_lvl", 32'(lvl), 32'd1);
        rst_n = 1'b0;
        #1;
        chk3("arst", 2'b00, 2'b00, 2'b00);
        raw = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk3($sformatf("inrst%0d", k), 2'b00, 2'b00, 2'b00);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk3($sformatf("post%0d", k), 2'b00, 2'b00, 2'b00);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
